// File: rtl/coin_accumulator.sv
// Coin intake stage for the vending machine.
// It converts single-cycle coin strobes into a registered running total.
// A coin that would push the total above MAX_TOTAL is refused.
// While the vending FSM dispenses, the total is frozen and every coin is refused.
// After TIMEOUT_CYCLES idle cycles in COLLECT, the whole total is refunded.
// A coin that is not added for any reason (overflow, clear, lock, refund)
// produces a coin_reject pulse, so the coin goes back to the user.
module coin_accumulator #(
  parameter logic [6:0]  MAX_TOTAL      = 7'd100,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       lock,
  input  logic       clear,
  output logic [6:0] total_coin_value,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic       refund_valid,
  output logic [6:0] refund_value,
  output logic       busy
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StCollect = 2'd1,
    StLocked  = 2'd2,
    StRefund  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      total_q, total_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept_q, accept_d;
  logic            reject_q, reject_d;
  logic            refundValid_q, refundValid_d;
  logic [6:0]      refundValue_q, refundValue_d;
  logic            busy_q, busy_d;

  logic [7:0]      coinValue;
  logic [7:0]      sum;
  logic            fits;
  logic            coinTaken;

  // Coin denomination decode and the 8-bit sum, so the overflow test never wraps
  always_comb begin
    coinValue = 8'd1;
    unique case (coin_type)
      2'b00:   coinValue = 8'd1;
      2'b01:   coinValue = 8'd2;
      2'b10:   coinValue = 8'd5;
      2'b11:   coinValue = 8'd10;
      default: coinValue = 8'd1;
    endcase
    sum       = {1'b0, total_q} + coinValue;
    fits      = (sum <= {1'b0, MAX_TOTAL});
    coinTaken = coin_valid && fits && !clear && !lock &&
                ((state_q == StEmpty) || (state_q == StCollect));
  end

  // State and output registers; reset has priority over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StEmpty;
      total_q       <= '0;
      cnt_q         <= '0;
      accept_q      <= 1'b0;
      reject_q      <= 1'b0;
      refundValid_q <= 1'b0;
      refundValue_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      total_q       <= total_d;
      cnt_q         <= cnt_d;
      accept_q      <= accept_d;
      reject_q      <= reject_d;
      refundValid_q <= refundValid_d;
      refundValue_q <= refundValue_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state selection; the priority order is clear, then lock, then coin, then timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (clear)                  state_d = StEmpty;
        else if (lock)              state_d = StLocked;
        else if (coin_valid && fits) state_d = StCollect;
      end
      StCollect: begin
        if (clear)                            state_d = StEmpty;
        else if (lock)                        state_d = StLocked;
        else if (!coin_valid && cnt_q == CntLast) state_d = StRefund;
      end
      StLocked: begin
        if (clear)      state_d = StEmpty;
        else if (!lock) state_d = (total_q != 7'd0) ? StCollect : StEmpty;
      end
      StRefund: state_d = StEmpty;
      default:  state_d = StEmpty;
    endcase
  end

  // Datapath and output pulses; the idle counter saturates when a refused coin arrives at the last count
  always_comb begin
    total_d       = total_q;
    cnt_d         = cnt_q;
    accept_d      = coinTaken;
    reject_d      = coin_valid && !coinTaken;
    refundValid_d = 1'b0;
    refundValue_d = '0;
    unique case (state_q)
      StEmpty: begin
        cnt_d = '0;
        if (coinTaken) total_d = sum[6:0];
      end
      StCollect: begin
        if (clear) begin
          total_d = '0;
          cnt_d   = '0;
        end else if (lock) begin
          cnt_d = cnt_q;
        end else if (coinTaken) begin
          total_d = sum[6:0];
          cnt_d   = '0;
        end else if (cnt_q != CntLast) begin
          cnt_d = cnt_q + 1'b1;
        end else if (!coin_valid) begin
          refundValid_d = 1'b1;
          refundValue_d = total_q;
        end
      end
      StLocked: begin
        if (clear) begin
          total_d = '0;
          cnt_d   = '0;
        end else if (!lock) begin
          cnt_d = '0;
        end
      end
      StRefund: begin
        total_d = '0;
        cnt_d   = '0;
      end
      default: begin
        total_d = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != StEmpty);
  end

  assign total_coin_value = total_q;
  assign coin_accept      = accept_q;
  assign coin_reject      = reject_q;
  assign refund_valid     = refundValid_q;
  assign refund_value     = refundValue_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Testbench for coin_accumulator.
// It runs three parts in order:
//   1. a table of directed vectors with hand-computed expectations;
//   2. hand-written timeout and refund sequences;
//   3. randomized traffic compared against a behavioural model.
// The model tracks the total, the idle count and lock/refund flags as plain integers.
module tb_coin_accumulator;

  localparam int Timeout = 8;
  localparam int MaxTotal = 100;

  typedef struct {
    string      name;
    logic       rst;
    logic       cv;
    logic [1:0] ct;
    logic       lk;
    logic       clr;
    logic [6:0] total;
    logic       acc;
    logic       rej;
    logic       rv;
    logic [6:0] rval;
    logic       busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, coin_valid, lock, clear;
  logic [1:0] coin_type;
  logic [6:0] total_coin_value, refund_value;
  logic       coin_accept, coin_reject, refund_valid, busy;

  int checks = 0;
  int errors = 0;

  vec_t table_q[$];

  int mTotal, mIdle;
  bit mLocked, mRefund;

  coin_accumulator #(
    .MAX_TOTAL(7'd100),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin_valid(coin_valid),
    .coin_type(coin_type),
    .lock(lock),
    .clear(clear),
    .total_coin_value(total_coin_value),
    .coin_accept(coin_accept),
    .coin_reject(coin_reject),
    .refund_valid(refund_valid),
    .refund_value(refund_value),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic r, logic cv, logic [1:0] ct, logic lk, logic clr,
                              int tot, logic acc, logic rej, logic rv, int rval, logic bz);
    vec_t v;
    v.name = n; v.rst = r; v.cv = cv; v.ct = ct; v.lk = lk; v.clr = clr;
    v.total = 7'(tot); v.acc = acc; v.rej = rej; v.rv = rv; v.rval = 7'(rval); v.busy = bz;
    return v;
  endfunction

  function automatic int coinVal(logic [1:0] t);
    case (t)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 10;
    endcase
  endfunction

  task automatic checkField(string n, string f, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", n, f, got, want);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    rst        = v.rst;
    coin_valid = v.cv;
    coin_type  = v.ct;
    lock       = v.lk;
    clear      = v.clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(vec_t v);
    checkField(v.name, "total", int'(total_coin_value), int'(v.total));
    checkField(v.name, "coin_accept", int'(coin_accept), int'(v.acc));
    checkField(v.name, "coin_reject", int'(coin_reject), int'(v.rej));
    checkField(v.name, "refund_valid", int'(refund_valid), int'(v.rv));
    checkField(v.name, "refund_value", int'(refund_value), int'(v.rval));
    checkField(v.name, "busy", int'(busy), int'(v.busy));
  endtask

  task automatic runVec(vec_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  // Behavioural reference.
  // COLLECT is simply "a nonzero total that is neither locked nor refunding".
  task automatic modelStep(inout vec_t v);
    int val;
    val = coinVal(v.ct);
    v.acc = 0; v.rej = 0; v.rv = 0; v.rval = 0;
    if (v.rst) begin
      mTotal = 0; mIdle = 0; mLocked = 0; mRefund = 0;
    end else if (mRefund) begin
      if (v.cv) v.rej = 1;
      mTotal = 0; mIdle = 0; mRefund = 0;
    end else if (mLocked) begin
      if (v.cv) v.rej = 1;
      if (v.clr) begin
        mTotal = 0; mLocked = 0; mIdle = 0;
      end else if (!v.lk) begin
        mLocked = 0; mIdle = 0;
      end
    end else if (v.clr) begin
      if (v.cv) v.rej = 1;
      mTotal = 0; mIdle = 0;
    end else if (v.lk) begin
      if (v.cv) v.rej = 1;
      mLocked = 1;
    end else if (v.cv) begin
      if (mTotal + val <= MaxTotal) begin
        mTotal += val; v.acc = 1; mIdle = 0;
      end else begin
        v.rej = 1;
        if (mTotal > 0 && mIdle < Timeout - 1) mIdle++;
      end
    end else if (mTotal > 0) begin
      if (mIdle == Timeout - 1) begin
        mRefund = 1; v.rv = 1; v.rval = 7'(mTotal);
      end else begin
        mIdle++;
      end
    end
    v.total = 7'(mTotal);
    v.busy  = mLocked || mRefund || (mTotal > 0);
  endtask

  initial begin
    vec_t v;
    int   coinPct;
    bit   lockState;

    rst = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; lock = 1'b0; clear = 1'b0;

    // Directed table: reset, accumulation, the 100 boundary, lock and clear interactions, reset in LOCKED
    table_q.push_back(mk("reset",       1, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0));
    table_q.push_back(mk("t1_coin10a",  0, 1, 2'b11, 0, 0,  10, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t1_coin10b",  0, 1, 2'b11, 0, 0,  20, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t1_coin5",    0, 1, 2'b10, 0, 0,  25, 1, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++)
      table_q.push_back(mk("t2_fill",   0, 1, 2'b11, 0, 0,  35 + 10 * i, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t2_to100",    0, 1, 2'b10, 0, 0, 100, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t2_over1",    0, 1, 2'b00, 0, 0, 100, 0, 1, 0, 0, 1));
    table_q.push_back(mk("t2_over10",   0, 1, 2'b11, 0, 0, 100, 0, 1, 0, 0, 1));
    table_q.push_back(mk("t2_clear",    0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      table_q.push_back(mk("t3_fill",   0, 1, 2'b11, 0, 0,  10 + 10 * i, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t3_lockcoin", 0, 1, 2'b11, 1, 0,  30, 0, 1, 0, 0, 1));
    table_q.push_back(mk("t3_lockedcn", 0, 1, 2'b00, 1, 0,  30, 0, 1, 0, 0, 1));
    table_q.push_back(mk("t3_lockhold", 0, 0, 2'b00, 1, 0,  30, 0, 0, 0, 0, 1));
    table_q.push_back(mk("t3_clear",    0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0));
    table_q.push_back(mk("t5_coin10a",  0, 1, 2'b11, 0, 0,  10, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t5_coin10b",  0, 1, 2'b11, 0, 0,  20, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t5_coin5",    0, 1, 2'b10, 0, 0,  25, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t5_clrcoin",  0, 1, 2'b10, 0, 1,   0, 0, 1, 0, 0, 0));
    table_q.push_back(mk("lf_coin10",   0, 1, 2'b11, 0, 0,  10, 1, 0, 0, 0, 1));
    table_q.push_back(mk("lf_lock",     0, 0, 2'b00, 1, 0,  10, 0, 0, 0, 0, 1));
    table_q.push_back(mk("lf_unlock",   0, 0, 2'b00, 0, 0,  10, 0, 0, 0, 0, 1));
    table_q.push_back(mk("lf_coin2",    0, 1, 2'b01, 0, 0,  12, 1, 0, 0, 0, 1));
    table_q.push_back(mk("lf_clear",    0, 0, 2'b00, 0, 1,   0, 0, 0, 0, 0, 0));
    table_q.push_back(mk("el_lock",     0, 0, 2'b00, 1, 0,   0, 0, 0, 0, 0, 1));
    table_q.push_back(mk("el_unlock",   0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      table_q.push_back(mk("t6_fill",   0, 1, 2'b11, 0, 0,  10 + 10 * i, 1, 0, 0, 0, 1));
    table_q.push_back(mk("t6_lock",     0, 0, 2'b00, 1, 0,  40, 0, 0, 0, 0, 1));
    table_q.push_back(mk("t6_rst",      1, 1, 2'b11, 1, 0,   0, 0, 0, 0, 0, 0));
    table_q.push_back(mk("t6_idle",     0, 0, 2'b00, 0, 0,   0, 0, 0, 0, 0, 0));

    foreach (table_q[i]) runVec(table_q[i]);

    // Timeout: coin 2, then eight idle cycles; the refund pulse appears after the eighth
    runVec(mk("t4_rst",   1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    runVec(mk("t4_coin2", 0, 1, 2'b01, 0, 0, 2, 1, 0, 0, 0, 1));
    for (int i = 0; i < Timeout - 1; i++)
      runVec(mk("t4_idle", 0, 0, 2'b00, 0, 0, 2, 0, 0, 0, 0, 1));
    runVec(mk("t4_refund", 0, 0, 2'b00, 0, 0, 2, 0, 0, 1, 2, 1));
    runVec(mk("t4_after",  0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

    // An accepted coin restarts the idle count; during REFUND a coin is rejected and clear/lock are ignored
    runVec(mk("r2_coin1", 0, 1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++)
      runVec(mk("r2_idleA", 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1));
    runVec(mk("r2_coin2", 0, 1, 2'b01, 0, 0, 3, 1, 0, 0, 0, 1));
    for (int i = 0; i < Timeout - 1; i++)
      runVec(mk("r2_idleB", 0, 0, 2'b00, 0, 0, 3, 0, 0, 0, 0, 1));
    runVec(mk("r2_refund", 0, 0, 2'b00, 0, 0, 3, 0, 0, 1, 3, 1));
    runVec(mk("r2_inref",  0, 1, 2'b11, 1, 1, 0, 0, 1, 0, 0, 0));
    runVec(mk("r2_empty",  0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic against the model, starting from a reset of both
    mTotal = 0; mIdle = 0; mLocked = 0; mRefund = 0;
    v = mk("rand_rst", 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    modelStep(v);
    runVec(v);
    coinPct   = 50;
    lockState = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) coinPct = ($urandom_range(0, 1) == 0) ? 8 : 60;
      if ($urandom_range(0, 23) == 0) lockState = ~lockState;
      v.name = "rand";
      v.rst  = ($urandom_range(0, 499) == 0);
      v.cv   = ($urandom_range(0, 99) < coinPct);
      v.ct   = 2'($urandom_range(0, 3));
      v.lk   = lockState;
      v.clr  = ($urandom_range(0, 63) == 0);
      modelStep(v);
      runVec(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
